bitplane_flush_sequencer: RTL and testbench

- Sequences the 64:1 bit mux (mux_6_bit) to flush the GSU pixel cache to RAM.
- The cache holds 8 pixels × 8 colour bits, packed 64 bits with index = pixel*8 + plane.
- The block drives the mux selector to gather one SNES bitplane byte at a time. Each byte is offered with a write mask to the RAM write port over a valid/ready handshake.
- It sits between the pixel cache / mux and the ROM/RAM bus arbiter.

---
 rtl/gsu_pkg.sv | 39 +++
 rtl/bitplane_flush_sequencer.sv | 142 ++++++++++++++
 tb/tb_bitplane_flush_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gsu_pkg.sv
// Shared definitions for the GSU pixel-cache flush path: sequencer state
// encoding, bitplane mode encodings and the mode-to-plane-count mapping.
package gsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GATHER  = 2'd1,
      ST_PRESENT = 2'd2,
      ST_FINISH  = 2'd3
   } state_t;

   localparam logic [1:0] BPP_2 = 2'b00;
   localparam logic [1:0] BPP_4 = 2'b01;
   localparam logic [1:0] BPP_8 = 2'b10;

   // Modes 10 and 11 both mean 8bpp; without 8bpp support they fall back to 4bpp.
   function automatic logic [3:0] planes_for_mode(input logic [1:0] mode, input logic en8);
      logic [3:0] n;
      if (mode == BPP_2) begin
         n = 4'd2;
      end else if (mode == BPP_4) begin
         n = 4'd4;
      end else if (en8) begin
         n = 4'd8;
      end else begin
         n = 4'd4;
      end
      return n;
   endfunction

   function automatic logic [7:0] reverse_byte(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[7-i] = b[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/bitplane_flush_sequencer.sv
// Walks the 64:1 cache mux one pixel per cycle to assemble SNES bitplane bytes
// and offers each byte, with its pixel write mask, over a valid/ready port.
module bitplane_flush_sequencer
   import gsu_pkg::*;
#(
   parameter bit ENABLE_8BPP = 1'b1,
   parameter bit MASK_OUTPUT = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] bpp_mode,
   input  logic [7:0] dirty_mask,
   output logic [5:0] mux_selector,
   input  logic       mux_bit,
   output logic [7:0] plane_data,
   output logic [2:0] plane_index,
   output logic [7:0] plane_mask,
   output logic       plane_valid,
   input  logic       plane_ready,
   output logic       busy,
   output logic       done
);

   state_t     state_q, state_d;
   logic [1:0] mode_q, mode_d;
   logic [2:0] pixel_q, pixel_d;
   logic [2:0] plane_q, plane_d;
   logic [7:0] shift_q, shift_d;
   logic [5:0] sel_q, sel_d;
   logic [7:0] data_q, data_d;
   logic [2:0] index_q, index_d;
   logic [7:0] mask_q, mask_d;
   logic       valid_q, valid_d;
   logic [3:0] n_planes;
   logic       last_plane;

   assign n_planes   = planes_for_mode(mode_q, ENABLE_8BPP);
   assign last_plane = ({1'b0, plane_q} == (n_planes - 4'd1));

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      pixel_d = pixel_q;
      plane_d = plane_q;
      shift_d = shift_q;
      sel_d   = sel_q;
      data_d  = data_q;
      index_d = index_q;
      mask_d  = mask_q;
      valid_d = valid_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (dirty_mask != 8'h00) begin
                  mode_d  = bpp_mode;
                  mask_d  = MASK_OUTPUT ? reverse_byte(dirty_mask) : 8'hFF;
                  pixel_d = 3'd0;
                  plane_d = 3'd0;
                  shift_d = 8'h00;
                  sel_d   = 6'd0;
                  state_d = ST_GATHER;
               end else begin
                  state_d = ST_FINISH;
               end
            end
         end

         // Selector already points at {pixel, plane}, so mux_bit belongs to pixel_q.
         ST_GATHER: begin
            shift_d[3'd7 - pixel_q] = mux_bit;
            pixel_d = pixel_q + 3'd1;
            if (pixel_q == 3'd7) begin
               data_d  = shift_d;
               index_d = plane_q;
               valid_d = 1'b1;
               state_d = ST_PRESENT;
            end else begin
               sel_d = {pixel_d, plane_q};
            end
         end

         ST_PRESENT: begin
            if (plane_ready) begin
               valid_d = 1'b0;
               if (last_plane) begin
                  state_d = ST_FINISH;
               end else begin
                  plane_d = plane_q + 3'd1;
                  pixel_d = 3'd0;
                  sel_d   = {3'd0, plane_d};
                  state_d = ST_GATHER;
               end
            end
         end

         ST_FINISH: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mode_q  <= 2'b00;
         pixel_q <= 3'd0;
         plane_q <= 3'd0;
         shift_q <= 8'h00;
         sel_q   <= 6'd0;
         data_q  <= 8'h00;
         index_q <= 3'd0;
         mask_q  <= 8'h00;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         pixel_q <= pixel_d;
         plane_q <= plane_d;
         shift_q <= shift_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         index_q <= index_d;
         mask_q  <= mask_d;
         valid_q <= valid_d;
      end
   end

   assign mux_selector = sel_q;
   assign plane_data   = data_q;
   assign plane_index  = index_q;
   assign plane_mask   = mask_q;
   assign plane_valid  = valid_q;
   assign busy         = (state_q != ST_IDLE);
   assign done         = (state_q == ST_FINISH);

endmodule

// File: tb/tb_bitplane_flush_sequencer.sv
// Self-checking bench: a behavioural cache/mux model feeds the sequencer and
// each scenario compares the accepted bytes and timing against plain arithmetic.
module tb_bitplane_flush_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [1:0] bpp_mode;
   logic [7:0] dirty_mask;
   logic [5:0] mux_selector;
   logic       mux_bit;
   logic [7:0] plane_data;
   logic [2:0] plane_index;
   logic [7:0] plane_mask;
   logic       plane_valid;
   logic       plane_ready;
   logic       busy;
   logic       done;

   logic [63:0] cache;
   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   assign mux_bit = cache[mux_selector];

   bitplane_flush_sequencer #(.ENABLE_8BPP(1'b1), .MASK_OUTPUT(1'b1)) dut (
      .clk(clk), .reset(reset), .start(start), .bpp_mode(bpp_mode),
      .dirty_mask(dirty_mask), .mux_selector(mux_selector), .mux_bit(mux_bit),
      .plane_data(plane_data), .plane_index(plane_index), .plane_mask(plane_mask),
      .plane_valid(plane_valid), .plane_ready(plane_ready), .busy(busy), .done(done)
   );

   // Observations from the most recent flush.
   logic [7:0] obs_data[$];
   logic [2:0] obs_index[$];
   logic [7:0] obs_mask[$];
   int         obs_edge[$];
   int         done_edge;
   int         busy_cycles;
   int         held_viol;
   bit         timed_out;
   logic       post_busy;
   logic       post_done;

   function automatic int planes_ref(input logic [1:0] m);
      if (m == 2'b00) return 2;
      if (m == 2'b01) return 4;
      return 8;
   endfunction

   // Plane p of pixel i lives at cache bit i*8+p; pixel 0 lands in bit 7.
   function automatic logic [7:0] ref_byte(input logic [63:0] c, input int p);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[7-i] = c[i*8+p];
      return b;
   endfunction

   function automatic logic [7:0] ref_mask(input logic [7:0] d);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[7-i] = d[i];
      return r;
   endfunction

   // Start a flush (start sampled at edge 0) and record every accepted byte with
   // the edge at which it was accepted, until done is seen. Edge k = k-th edge after start.
   task automatic run_flush(input logic [1:0] mode, input logic [7:0] dm, input int ready_kind,
                            input int stall_plane, input int stall_len, input int inject_at);
      int c;
      int stall_left;
      bit stalled_once;
      bit holding;
      logic [7:0] hd, hm;
      logic [2:0] hi;
      obs_data.delete(); obs_index.delete(); obs_mask.delete(); obs_edge.delete();
      done_edge = -1; busy_cycles = 0; held_viol = 0; timed_out = 1'b0;
      c = 0; stall_left = 0; stalled_once = 1'b0; holding = 1'b0;
      hd = 8'h00; hm = 8'h00; hi = 3'd0;
      @(negedge clk);
      start = 1'b1; bpp_mode = mode; dirty_mask = dm; plane_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; bpp_mode = 2'($urandom); dirty_mask = 8'($urandom);
      while (done_edge < 0) begin
         if (c > 2000) begin
            timed_out = 1'b1;
            break;
         end
         if (holding && (!plane_valid || plane_data !== hd || plane_index !== hi || plane_mask !== hm))
            held_viol++;
         if (busy) busy_cycles++;
         if (done) done_edge = c + 1;
         start = (c == inject_at);
         if (plane_valid && int'(plane_index) == stall_plane && !stalled_once) begin
            stalled_once = 1'b1;
            stall_left = stall_len;
         end
         if (stall_left > 0) begin
            plane_ready = 1'b0;
            stall_left--;
         end else begin
            plane_ready = (ready_kind == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         holding = plane_valid && !plane_ready;
         hd = plane_data; hi = plane_index; hm = plane_mask;
         if (plane_valid && plane_ready) begin
            obs_data.push_back(plane_data);
            obs_index.push_back(plane_index);
            obs_mask.push_back(plane_mask);
            obs_edge.push_back(c + 1);
         end
         @(posedge clk); #1;
         c++;
      end
      start = 1'b0;
      post_busy = busy;
      post_done = done;
      $display("flush mode=%0d dirty=%02h bytes=%0d done_edge=%0d", mode, dm, obs_data.size(), done_edge);
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; bpp_mode = 2'b00; dirty_mask = 8'h00; plane_ready = 1'b0;
      cache = 64'h0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({mux_selector, plane_data, plane_index, plane_mask, plane_valid, busy, done} !== 29'd0)
         $display("FAIL reset_outputs: got sel=%0d data=%02h idx=%0d mask=%02h v=%b busy=%b done=%b, want all 0",
                  mux_selector, plane_data, plane_index, plane_mask, plane_valid, busy, done);
      else passed++;
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || plane_valid !== 1'b0 || done !== 1'b0)
         $display("FAIL idle_without_start: got busy=%b valid=%b done=%b, want 0 0 0", busy, plane_valid, done);
      else passed++;
   endtask

   // Ready held high: bytes at edges 9,18,..., done at 9N+1.
   task automatic test_ready_high();
      logic [1:0] modes[4] = '{2'b00, 2'b10, 2'b01, 2'b11};
      for (int m = 0; m < 4; m++) begin
         int n;
         cache = 64'h0123_4567_89AB_CDEF;
         n = planes_ref(modes[m]);
         run_flush(modes[m], 8'hFF, 0, -1, 0, -1);
         checks++;
         if (timed_out || obs_data.size() != n)
            $display("FAIL rh_count mode=%0d: got %0d bytes (timeout=%b), want %0d", modes[m], obs_data.size(), timed_out, n);
         else passed++;
         for (int k = 0; k < obs_data.size() && k < n; k++) begin
            checks++;
            if (obs_data[k] !== ref_byte(cache, k) || int'(obs_index[k]) != k || obs_mask[k] !== 8'hFF || obs_edge[k] != 9*(k+1))
               $display("FAIL rh_byte mode=%0d k=%0d: got data=%02h idx=%0d mask=%02h edge=%0d, want %02h %0d FF %0d",
                        modes[m], k, obs_data[k], obs_index[k], obs_mask[k], obs_edge[k], ref_byte(cache, k), k, 9*(k+1));
            else passed++;
         end
         checks++;
         if (done_edge != 9*n + 1 || post_busy !== 1'b0 || post_done !== 1'b0)
            $display("FAIL rh_done mode=%0d: got done_edge=%0d post_busy=%b post_done=%b, want %0d 0 0",
                     modes[m], done_edge, post_busy, post_done, 9*n + 1);
         else passed++;
      end
   endtask

   task automatic test_stall();
      cache = {$urandom, $urandom};
      run_flush(2'b01, 8'b0000_0101, 0, 2, 5, -1);
      checks++;
      if (timed_out || obs_data.size() != 4)
         $display("FAIL stall_count: got %0d bytes (timeout=%b), want 4", obs_data.size(), timed_out);
      else passed++;
      checks++;
      if (held_viol != 0)
         $display("FAIL stall_hold: got %0d changes while stalled, want 0", held_viol);
      else passed++;
      for (int k = 0; k < obs_data.size() && k < 4; k++) begin
         checks++;
         if (obs_data[k] !== ref_byte(cache, k) || int'(obs_index[k]) != k || obs_mask[k] !== 8'hA0)
            $display("FAIL stall_byte k=%0d: got data=%02h idx=%0d mask=%02h, want %02h %0d A0",
                     k, obs_data[k], obs_index[k], obs_mask[k], ref_byte(cache, k), k);
         else passed++;
      end
      checks++;
      if (done_edge != 9*4 + 1 + 5)
         $display("FAIL stall_done: got done_edge=%0d, want %0d", done_edge, 9*4 + 1 + 5);
      else passed++;
   endtask

   task automatic test_zero_mask();
      run_flush(2'b10, 8'h00, 0, -1, 0, -1);
      checks++;
      if (timed_out || obs_data.size() != 0 || done_edge != 1 || busy_cycles != 1 || post_busy !== 1'b0)
         $display("FAIL zero_mask: got bytes=%0d done_edge=%0d busy_cycles=%0d post_busy=%b, want 0 1 1 0",
                  obs_data.size(), done_edge, busy_cycles, post_busy);
      else passed++;
   endtask

   // Start during GATHER is ignored; a start right after FINISH begins a fresh flush.
   task automatic test_back_to_back();
      cache = {$urandom, $urandom};
      run_flush(2'b00, 8'h3C, 0, -1, 0, 2);
      checks++;
      if (timed_out || obs_data.size() != 2 || done_edge != 19)
         $display("FAIL b2b_ignore: got bytes=%0d done_edge=%0d, want 2 19", obs_data.size(), done_edge);
      else passed++;
      run_flush(2'b01, 8'h81, 0, -1, 0, -1);
      checks++;
      if (timed_out || obs_data.size() != 4 || done_edge != 37 || obs_mask[0] !== 8'h81 || obs_data[0] !== ref_byte(cache, 0))
         $display("FAIL b2b_restart: got bytes=%0d done_edge=%0d, want 4 37", obs_data.size(), done_edge);
      else passed++;
   endtask

   task automatic test_reset_mid();
      int c;
      logic [7:0] dm;
      cache = {$urandom, $urandom};
      dm = 8'($urandom) | 8'h01;
      @(negedge clk);
      start = 1'b1; bpp_mode = 2'b10; dirty_mask = dm; plane_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      c = 0;
      while (!(plane_valid && plane_index == 3'd1) && c < 100) begin
         @(posedge clk); #1;
         c++;
      end
      checks++;
      if (c >= 100) $display("FAIL rmid_reach_plane1: got timeout after %0d cycles, want plane 1 valid", c);
      else passed++;
      plane_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({mux_selector, plane_data, plane_index, plane_mask, plane_valid, busy, done} !== 29'd0)
         $display("FAIL rmid_outputs: got sel=%0d data=%02h idx=%0d mask=%02h v=%b busy=%b done=%b, want all 0",
                  mux_selector, plane_data, plane_index, plane_mask, plane_valid, busy, done);
      else passed++;
      reset = 1'b0;
      plane_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (plane_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL rmid_no_partial: got valid=%b busy=%b, want 0 0", plane_valid, busy);
      else passed++;
      run_flush(2'b10, dm, 0, -1, 0, -1);
      checks++;
      if (timed_out || obs_data.size() != 8 || obs_index[0] !== 3'd0 || obs_data[0] !== ref_byte(cache, 0)
          || obs_mask[0] !== ref_mask(dm) || obs_edge[0] != 9)
         $display("FAIL rmid_restart: got bytes=%0d first idx/data/mask/edge mismatch, want 8 bytes from plane 0 at edge 9",
                  obs_data.size());
      else passed++;
   endtask

   task automatic test_random();
      for (int it = 0; it < 16; it++) begin
         logic [1:0] mode;
         logic [7:0] dm;
         int n;
         bit spacing_ok;
         cache = {$urandom, $urandom};
         mode = 2'($urandom);
         dm = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         n = (dm == 8'h00) ? 0 : planes_ref(mode);
         run_flush(mode, dm, 1, -1, 0, -1);
         checks++;
         if (timed_out || obs_data.size() != n || held_viol != 0 || post_busy !== 1'b0)
            $display("FAIL rnd_shape it=%0d: got bytes=%0d held_viol=%0d timeout=%b post_busy=%b, want %0d 0 0 0",
                     it, obs_data.size(), held_viol, timed_out, post_busy, n);
         else passed++;
         spacing_ok = 1'b1;
         for (int k = 0; k < obs_data.size() && k < n; k++) begin
            if (k > 0 && obs_edge[k] - obs_edge[k-1] < 9) spacing_ok = 1'b0;
            checks++;
            if (obs_data[k] !== ref_byte(cache, k) || int'(obs_index[k]) != k || obs_mask[k] !== ref_mask(dm))
               $display("FAIL rnd_byte it=%0d k=%0d: got data=%02h idx=%0d mask=%02h, want %02h %0d %02h",
                        it, k, obs_data[k], obs_index[k], obs_mask[k], ref_byte(cache, k), k, ref_mask(dm));
            else passed++;
         end
         checks++;
         if (!spacing_ok) $display("FAIL rnd_spacing it=%0d: got bytes closer than 9 edges, want >= 9", it);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_ready_high();
      test_stall();
      test_zero_mask();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
